// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : shared constants and helpers for the up/down counter family
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DN    = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    function automatic int clog2(input longint unsigned value);
        int bits;
        bits = 0;
        while ((64'd1 << bits) < value) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cascade_counter_tb_top.sv
// ============================================================================
// cascade_counter_tb_top : two mod-10 stages chained as a BCD 00..99 counter
// Rev 1.0
// ============================================================================
`default_nettype none

module cascade_counter_tb_top
    import counter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up_dn,
    output logic [3:0] q_lo,
    output logic [3:0] q_hi,
    output logic       tc,
    output logic       wrapped_lo,
    output logic       wrapped_hi
);

    logic w_tc_lo;
    logic w_sat_lo;
    logic w_sat_hi;

    mod_updown_counter #(
        .WIDTH (4), .MODULUS (10), .SATURATE (MODE_WRAP)
    ) u_lo (
        .clk (clk), .reset (reset), .en (en), .up_dn (up_dn),
        .load (1'b0), .load_val (4'd0),
        .q (q_lo), .tc (w_tc_lo), .wrapped (wrapped_lo), .sat (w_sat_lo)
    );

    // Same clock for both stages; the high stage is merely enabled by the low tc.
    mod_updown_counter #(
        .WIDTH (4), .MODULUS (10), .SATURATE (MODE_WRAP)
    ) u_hi (
        .clk (clk), .reset (reset), .en (w_tc_lo), .up_dn (up_dn),
        .load (1'b0), .load_val (4'd0),
        .q (q_hi), .tc (tc), .wrapped (wrapped_hi), .sat (w_sat_hi)
    );

    logic w_unused;
    assign w_unused = w_sat_lo ^ w_sat_hi;

endmodule

`default_nettype wire

// File: rtl/mod_step.sv
// ============================================================================
// mod_step : combinational modulo-N increment/decrement with terminal detect
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_step
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] next_o,
    output logic             at_term_o,
    output logic             wrap_flag_o
);

    localparam logic [WIDTH:0]   c_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;

    assign w_ext = {1'b0, q_i};
    assign w_inc = w_ext + 1'b1;
    assign w_dec = w_ext - 1'b1;

    // Up: terminal when q+1 reaches MODULUS (the carry itself for power-of-two).
    // Down: terminal when q-1 borrows out of the extended width.
    assign at_term_o   = (up_dn_i == CNT_UP) ? (w_inc == c_MOD) : w_dec[WIDTH];
    assign wrap_flag_o = at_term_o;

    always_comb begin
        next_o = (up_dn_i == CNT_UP) ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
        if (at_term_o) begin
            next_o = (up_dn_i == CNT_UP) ? '0 : c_TOP;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ============================================================================
// mod_updown_counter : parametrised synchronous up/down counter, cascadable
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped,
    output logic             sat
);

    localparam logic [WIDTH-1:0] c_TOP = WIDTH'(MODULUS - 1);
    localparam logic             c_SAT = (SATURATE == MODE_SAT);

    if ((WIDTH < 1) || (WIDTH > 32) || (MODULUS < 2) || (MODULUS > (64'd1 << WIDTH)))
    begin : g_param_check
        $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrapped_q, wrapped_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] w_next;
    logic             w_at_term;
    logic             w_wrap;

    mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q_i         (cnt_q),
        .up_dn_i     (up_dn),
        .next_o      (w_next),
        .at_term_o   (w_at_term),
        .wrap_flag_o (w_wrap)
    );

    always_comb begin
        cnt_d     = cnt_q;
        wrapped_d = 1'b0;
        sat_d     = sat_q;
        if (load) begin
            cnt_d = (load_val > c_TOP) ? c_TOP : load_val;
            sat_d = 1'b0;
        end else if (en) begin
            if (w_at_term && c_SAT) begin
                sat_d = 1'b1;
            end else begin
                cnt_d     = w_next;
                wrapped_d = w_wrap;
                sat_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wrapped_q <= wrapped_d;
            sat_q     <= sat_d;
        end
    end

    assign q       = cnt_q;
    assign tc      = en & w_at_term;
    assign wrapped = wrapped_q;
    assign sat     = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ============================================================================
// tb_mod_updown_counter : scoreboard bench for the up/down counter family
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mod_updown_counter;
    import counter_pkg::*;

    localparam int W10 = clog2(10);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q16, q10w, q10s, qlo, qhi;
    logic       tc16, tc10w, tc10s, tcc;
    logic       w16, w10w, w10s, wlo, whi;
    logic       s16, s10w, s10s;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(MODE_WRAP)) u_m16 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q(q16), .tc(tc16), .wrapped(w16), .sat(s16));

    mod_updown_counter #(.WIDTH(W10), .MODULUS(10), .SATURATE(MODE_WRAP)) u_m10w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q(q10w), .tc(tc10w), .wrapped(w10w), .sat(s10w));

    mod_updown_counter #(.WIDTH(W10), .MODULUS(10), .SATURATE(MODE_SAT)) u_m10s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q(q10s), .tc(tc10s), .wrapped(w10s), .sat(s10s));

    cascade_counter_tb_top u_bcd (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .q_lo(qlo), .q_hi(qhi), .tc(tcc), .wrapped_lo(wlo), .wrapped_hi(whi));

    // For the cascade (sel 3): q={hi,lo}, tc=high-stage tc, w=wrapped_hi, s=wrapped_lo.
    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] q;
        logic       tc;
        logic       w;
        logic       s;
        logic [7:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [10:0] observe(input logic [1:0] s);
        case (s)
            2'd0:    return {4'd0, q16,  tc16,  w16,  s16};
            2'd1:    return {4'd0, q10w, tc10w, w10w, s10w};
            2'd2:    return {4'd0, q10s, tc10s, w10s, s10s};
            default: return {qhi, qlo, tcc, whi, wlo};
        endcase
    endfunction

    // Monitor: every edge with a pending expectation is checked 1 time unit later.
    always @(posedge clk) begin
        exp_t        e;
        logic [10:0] act;
        #1;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = observe(e.sel);
            n_tests++;
            if (act != {e.q, e.tc, e.w, e.s}) begin
                n_fail++;
                $display("FAIL step tag=%0d sel=%0d: got q=%0h tc=%0b wrapped=%0b sat=%0b, want q=%0h tc=%0b wrapped=%0b sat=%0b",
                         e.tag, e.sel, act[10:3], act[2], act[1], act[0], e.q, e.tc, e.w, e.s);
            end
        end
    end

    task automatic step(input logic [1:0] s, input logic r, input logic e_i, input logic u,
                        input logic l, input logic [3:0] lv, input logic [7:0] eq,
                        input logic etc, input logic ew, input logic es, input logic [7:0] tag);
        exp_t x;
        @(negedge clk);
        reset = r; en = e_i; up_dn = u; load = l; load_val = lv;
        x.sel = s; x.q = eq; x.tc = etc; x.w = ew; x.s = es; x.tag = tag;
        sb.push_back(x);
    endtask

    initial begin
        // 1: mod-16 wrap up, then a short down step across zero
        step(0, 1, 0, 1, 0, 0, 8'd0, 0, 0, 0, 8'd10);
        for (int i = 1; i <= 17; i++) begin
            step(0, 0, 1, 1, 0, 0, 8'(i % 16), (i % 16) == 15, i == 16, 0, 8'd11);
        end
        step(0, 0, 1, 0, 0, 0, 8'd0,  1, 0, 0, 8'd12);
        step(0, 0, 1, 0, 0, 0, 8'd15, 0, 1, 0, 8'd13);
        step(0, 0, 0, 1, 1, 4'd15, 8'd15, 0, 0, 0, 8'd14);

        // 2: mod-10 down count from 3
        step(1, 0, 0, 1, 1, 4'd3, 8'd3, 0, 0, 0, 8'd20);
        step(1, 0, 1, 0, 0, 0, 8'd2, 0, 0, 0, 8'd21);
        step(1, 0, 1, 0, 0, 0, 8'd1, 0, 0, 0, 8'd22);
        step(1, 0, 1, 0, 0, 0, 8'd0, 1, 0, 0, 8'd23);
        step(1, 0, 1, 0, 0, 0, 8'd9, 0, 1, 0, 8'd24);
        step(1, 0, 1, 0, 0, 0, 8'd8, 0, 0, 0, 8'd25);

        // 3: saturate up at 9, hold sat while idle, clear on load, saturate down at 0
        step(2, 0, 0, 1, 1, 4'd7, 8'd7, 0, 0, 0, 8'd30);
        step(2, 0, 1, 1, 0, 0, 8'd8, 0, 0, 0, 8'd31);
        step(2, 0, 1, 1, 0, 0, 8'd9, 1, 0, 0, 8'd32);
        step(2, 0, 1, 1, 0, 0, 8'd9, 1, 0, 1, 8'd33);
        step(2, 0, 1, 1, 0, 0, 8'd9, 1, 0, 1, 8'd34);
        step(2, 0, 1, 1, 0, 0, 8'd9, 1, 0, 1, 8'd35);
        step(2, 0, 0, 1, 0, 0, 8'd9, 0, 0, 1, 8'd36);
        step(2, 0, 0, 1, 1, 4'd2, 8'd2, 0, 0, 0, 8'd37);
        step(2, 0, 1, 0, 0, 0, 8'd1, 0, 0, 0, 8'd38);
        step(2, 0, 1, 0, 0, 0, 8'd0, 1, 0, 0, 8'd39);
        step(2, 0, 1, 0, 0, 0, 8'd0, 1, 0, 1, 8'd40);

        // 4: load beats enable and clamps; reset beats load and enable
        step(1, 0, 1, 1, 1, 4'd13, 8'd9, 1, 0, 0, 8'd50);
        step(1, 1, 1, 1, 1, 4'd5,  8'd0, 0, 0, 0, 8'd51);

        // 5: mid-count reset, then direction flip to down
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 1, 1, 0, 0, 8'(i), 0, 0, 0, 8'd60);
        end
        step(1, 1, 1, 0, 0, 0, 8'd0, 1, 0, 0, 8'd61);
        step(1, 0, 1, 0, 0, 0, 8'd9, 0, 1, 0, 8'd62);

        // 6: BCD cascade 00..99 then 00
        step(3, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'd70);
        for (int i = 1; i <= 100; i++) begin
            int v;
            v = i % 100;
            step(3, 0, 1, 1, 0, 0, {4'(v / 10), 4'(v % 10)}, v == 99, i == 100,
                 (i % 10) == 0, 8'd71);
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0; reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
